// File: rtl/cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cic_decim_ctrl
//  Purpose  : Sequencer for a CIC decimator (STAGES integrators + STAGES
//             combs). It gates the integrator strobe, counts accepted samples
//             modulo the runtime rate, issues the comb strobe at each
//             decimation boundary, and applies rate changes safely: it applies
//             a new rate at a boundary, clears integrators and combs, then
//             flushes until the comb history has been refilled.
//  Ports    : clk, reset        clock / synchronous active-high reset
//             enable            run request, low forces IDLE
//             inp_samp_str      input sample valid
//             rate, rate_wr     requested rate and its one-cycle write strobe
//             rate_ack/rate_err registered pulses: rate applied / write refused
//             int_str,int_clear integrator strobe and clear
//             comb_str,comb_clear comb strobe and delay-line clear
//             out_samp_str      decimated output valid
//             cur_rate, busy    active rate, state != RUN
//  Revision : 1.0  initial release
// ============================================================================
module cic_decim_ctrl #(
   parameter  int R_MAX        = 64,
   parameter  int STAGES       = 4,
   parameter  int RATE_DEFAULT = 8,
   localparam int RATE_W       = $clog2(R_MAX + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              inp_samp_str,
   input  logic [RATE_W-1:0] rate,
   input  logic              rate_wr,
   output logic              rate_ack,
   output logic              rate_err,
   output logic              int_str,
   output logic              int_clear,
   output logic              comb_str,
   output logic              comb_clear,
   output logic              out_samp_str,
   output logic [RATE_W-1:0] cur_rate,
   output logic              busy
);

   localparam int FL_W    = (STAGES > 1) ? $clog2(STAGES + 1) : 1;
   localparam int FL_LAST = (STAGES > 0) ? STAGES - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_FLUSH = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [RATE_W-1:0] r_dec_cnt;
   logic [FL_W-1:0]   r_flush_cnt;
   logic [RATE_W-1:0] r_cur_rate;
   logic              r_pend_valid;
   logic [RATE_W-1:0] r_pend_rate;
   logic              r_comb_str;
   logic              r_out_str;
   logic              r_rate_ack;
   logic              r_rate_err;

   logic              w_int_str;
   logic              w_clear;
   logic              w_busy;
   logic              w_bnd;
   logic              w_rate_ok;
   logic [RATE_W-1:0] w_last;

   // cur_rate is never 0, so the subtraction cannot wrap
   assign w_last    = r_cur_rate - RATE_W'(1);
   assign w_rate_ok = (rate != '0) && (rate <= RATE_W'(R_MAX));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_int_str   = 1'b0;
      w_clear     = 1'b0;
      w_busy      = 1'b1;
      w_bnd       = 1'b0;

      w_int_str = inp_samp_str && ((r_state == S_FLUSH) || (r_state == S_RUN));
      w_bnd     = w_int_str && (r_dec_cnt == w_last);
      w_clear   = (r_state == S_CLEAR);
      w_busy    = (r_state != S_RUN);

      case (r_state)
         S_IDLE:  w_state_nxt = S_CLEAR;
         S_CLEAR: w_state_nxt = (STAGES == 0) ? S_RUN : S_FLUSH;
         // The flush ends on the STAGES-th boundary after the clear; that
         // boundary's comb output still belongs to the flush and is hidden.
         S_FLUSH: if (w_bnd && (r_flush_cnt == FL_W'(FL_LAST))) w_state_nxt = S_RUN;
         S_RUN:   if (w_bnd && r_pend_valid) w_state_nxt = S_CLEAR;
         default: w_state_nxt = S_IDLE;
      endcase

      if (!enable) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dec_cnt    <= '0;
         r_flush_cnt  <= '0;
         r_cur_rate   <= RATE_W'(RATE_DEFAULT);
         r_pend_valid <= 1'b0;
         r_pend_rate  <= '0;
         r_comb_str   <= 1'b0;
         r_out_str    <= 1'b0;
         r_rate_ack   <= 1'b0;
         r_rate_err   <= 1'b0;
      end else begin
         // Comb strobe lags the boundary by one cycle so the comb sees the
         // integrator output that includes the boundary sample.
         r_comb_str <= w_bnd;
         r_out_str  <= w_bnd && (r_state == S_RUN);
         r_rate_ack <= 1'b0;
         r_rate_err <= rate_wr && !w_rate_ok;

         if (r_state == S_CLEAR) begin
            r_dec_cnt   <= '0;
            r_flush_cnt <= '0;
            if (r_pend_valid) begin
               r_cur_rate <= r_pend_rate;
               r_rate_ack <= 1'b1;
            end
         end else begin
            if (w_bnd) begin
               r_dec_cnt <= '0;
            end else if (w_int_str) begin
               r_dec_cnt <= r_dec_cnt + RATE_W'(1);
            end
            if (w_bnd && (r_state == S_FLUSH)) begin
               r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end
         end

         // A write landing on the CLEAR cycle survives as the next pending rate.
         if (rate_wr && w_rate_ok) begin
            r_pend_valid <= 1'b1;
            r_pend_rate  <= rate;
         end else if (r_state == S_CLEAR) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   assign int_str      = w_int_str;
   assign int_clear    = w_clear;
   assign comb_clear   = w_clear;
   assign comb_str     = r_comb_str;
   assign out_samp_str = r_out_str;
   assign rate_ack     = r_rate_ack;
   assign rate_err     = r_rate_err;
   assign cur_rate     = r_cur_rate;
   assign busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_decim_ctrl
//  Purpose  : Self-checking bench for cic_decim_ctrl. A sample-counting
//             reference model (samples since clear, boundaries since clear,
//             pending rate) predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cic_decim_ctrl;

   localparam int STG = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       inp_samp_str;
   logic [6:0] rate;
   logic       rate_wr;
   logic       rate_ack, rate_err, int_str, int_clear, comb_str, comb_clear;
   logic       out_samp_str, busy;
   logic [6:0] cur_rate;

   int checks = 0;
   int errors = 0;

   // reference model
   bit m_active, m_clr, m_pend;
   int m_k, m_bidx, m_cur, m_prate;
   bit e_comb, e_out, e_ack, e_err;

   int n_comb, n_out, n_ack, n_err, n_clr;

   cic_decim_ctrl #(.R_MAX(64), .STAGES(STG), .RATE_DEFAULT(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .inp_samp_str(inp_samp_str),
      .rate(rate), .rate_wr(rate_wr), .rate_ack(rate_ack), .rate_err(rate_err),
      .int_str(int_str), .int_clear(int_clear), .comb_str(comb_str),
      .comb_clear(comb_clear), .out_samp_str(out_samp_str),
      .cur_rate(cur_rate), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_clr = 0; m_pend = 0;
      m_k = 0; m_bidx = 0; m_cur = 8; m_prate = 0;
      e_comb = 0; e_out = 0; e_ack = 0; e_err = 0;
   endtask

   task automatic zero_counts();
      n_comb = 0; n_out = 0; n_ack = 0; n_err = 0; n_clr = 0;
   endtask

   // One clock: drive inputs, check outputs, advance the model across the edge.
   task automatic cyc(input bit en, input bit samp, input bit wr, input int rt);
      bit e_int, bnd, bad, good, go_clear;
      enable = en; inp_samp_str = samp; rate_wr = wr; rate = 7'(rt);
      #1;
      e_int = samp && m_active;
      chk("int_str",    int_str,      e_int);
      chk("int_clear",  int_clear,    m_clr);
      chk("comb_clear", comb_clear,   m_clr);
      chk("comb_str",   comb_str,     e_comb);
      chk("out_str",    out_samp_str, e_out);
      chk("rate_ack",   rate_ack,     e_ack);
      chk("rate_err",   rate_err,     e_err);
      chk("cur_rate",   cur_rate,     8'(m_cur));
      chk("busy",       busy,         !(m_active && m_bidx >= STG));
      n_comb += int'(comb_str); n_out += int'(out_samp_str);
      n_ack  += int'(rate_ack); n_err += int'(rate_err);
      n_clr  += int'(int_clear);

      if (reset) begin
         model_reset();
      end else begin
         bnd      = e_int && (((m_k + 1) % m_cur) == 0);
         bad      = wr && (rt == 0 || rt > 64);
         good     = wr && !bad;
         go_clear = m_active && bnd && (m_bidx >= STG) && m_pend;
         e_comb   = bnd;
         e_out    = bnd && (m_bidx >= STG);
         e_err    = bad;
         e_ack    = 0;
         if (m_clr) begin
            m_k = 0; m_bidx = 0;
            if (m_pend) begin m_cur = m_prate; e_ack = 1; m_pend = 0; end
         end else if (e_int) begin
            m_k++;
            if (bnd) m_bidx++;
         end
         if (good) begin m_pend = 1; m_prate = rt; end
         if (!en) begin
            m_active = 0; m_clr = 0;
         end else if (m_clr) begin
            m_clr = 0; m_active = 1;
         end else if (!m_active) begin
            m_clr = 1;
         end else if (go_clear) begin
            m_active = 0; m_clr = 1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int rr;
      reset = 1; enable = 0; inp_samp_str = 0; rate_wr = 0; rate = '0;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      zero_counts();
      cyc(0, 1, 0, 0);
      chk("reset_busy", busy, 1'b1);
      chk("reset_rate", cur_rate, 8'd8);
      reset = 0;
      cyc(0, 1, 0, 0);

      // 1: defaults, 48 consecutive accepted samples
      zero_counts();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 48; i++) cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("t1_clears", 8'(n_clr), 8'd1);
      chk("t1_combs",  8'(n_comb), 8'd6);
      chk("t1_outs",   8'(n_out), 8'd2);
      chk("t1_busy",   busy, 1'b0);

      // 3: illegal writes
      zero_counts();
      cyc(1, 0, 1, 0);
      cyc(1, 0, 1, 65);
      cyc(1, 0, 0, 0);
      chk("t3_errs", 8'(n_err), 8'd2);
      chk("t3_acks", 8'(n_ack), 8'd0);
      chk("t3_rate", cur_rate, 8'd8);

      // 2: rate 4 written after the 3rd sample of a frame
      zero_counts();
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
      cyc(1, 0, 1, 4);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
      for (int i = 0; i < 33; i++) cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("t2_acks",  8'(n_ack), 8'd1);
      chk("t2_combs", 8'(n_comb), 8'd9);
      chk("t2_outs",  8'(n_out), 8'd5);
      chk("t2_rate",  cur_rate, 8'd4);

      // 4: rate 1 with continuous strobes
      zero_counts();
      cyc(1, 0, 1, 1);
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("t4_rate",  cur_rate, 8'd1);
      chk("t4_combs", 8'(n_comb), 8'd16);
      chk("t4_outs",  8'(n_out), 8'd12);

      // 5: enable low mid-stream while strobes keep coming
      zero_counts();
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
      chk("t5_idle_combs", 8'(n_comb), 8'd1);
      for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0);
      chk("t5_clears", 8'(n_clr), 8'd1);

      // 6: reset while flushing with a rate pending
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 1, 16);
      cyc(1, 0, 0, 0);
      chk("t6_flushing", busy, 1'b1);
      zero_counts();
      reset = 1;
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      reset = 0;
      for (int i = 0; i < 40; i++) cyc(1, 1, 0, 0);
      chk("t6_acks", 8'(n_ack), 8'd0);
      chk("t6_rate", cur_rate, 8'd8);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         rr = ($urandom % 8 == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(0, 6));
         reset = ($urandom % 300 == 0);
         cyc(($urandom % 16) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0, rr);
      end
      reset = 0;
      cyc(1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
